// File: rtl/interrupt_sequencer_if.sv
// Bus and request bundle between the 8227 decoder/core and the interrupt sequencer.
interface interrupt_sequencer_if;
  logic       nonMaskableInterrupt;
  logic       interruptRequest;
  logic       brkRequest;
  logic       instructionBoundary;
  logic       interruptDisable;
  logic [7:0] pcHigh;
  logic [7:0] pcLow;
  logic [7:0] statusReg;
  logic [7:0] stackPointer;
  logic       busy;
  logic [7:0] addressHigh;
  logic [7:0] addressLow;
  logic [7:0] dataOut;
  logic       writeEnable;
  logic       spDecrement;
  logic       loadPcLow;
  logic       loadPcHigh;
  logic       setInterruptDisable;

  modport master (
    input  nonMaskableInterrupt, interruptRequest, brkRequest, instructionBoundary,
           interruptDisable, pcHigh, pcLow, statusReg, stackPointer,
    output busy, addressHigh, addressLow, dataOut, writeEnable, spDecrement,
           loadPcLow, loadPcHigh, setInterruptDisable
  );

  modport slave (
    output nonMaskableInterrupt, interruptRequest, brkRequest, instructionBoundary,
           interruptDisable, pcHigh, pcLow, statusReg, stackPointer,
    input  busy, addressHigh, addressLow, dataOut, writeEnable, spDecrement,
           loadPcLow, loadPcHigh, setInterruptDisable
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// 7-cycle reset/NMI/IRQ/BRK entry for the 8227: push PCH, PCL, P then fetch the vector.
// Owns NMI edge latching and request priority; outputs decode from registered state.
module interrupt_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  interrupt_sequencer_if.master  bus
);
  typedef enum logic [2:0] {IDLE, S1, S2, S3, S4, S5, S6, S7} state_t;
  typedef enum logic [1:0] {K_RESET, K_NMI, K_IRQ, K_BRK} kind_t;

  state_t state, nextState;
  kind_t  kind, nextKind;
  logic   nmiPending, nextNmiPending;
  logic   nmiPrev, nmiEdge;
  logic [7:0] vecLo;

  assign nmiEdge = bus.nonMaskableInterrupt & ~nmiPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S1;
      kind       <= K_RESET;
      nmiPending <= 1'b0;
      nmiPrev    <= 1'b0;
    end else begin
      state      <= nextState;
      kind       <= nextKind;
      nmiPending <= nextNmiPending;
      nmiPrev    <= bus.nonMaskableInterrupt;
    end
  end

  always_comb begin
    nextState      = state;
    nextKind       = kind;
    nextNmiPending = nmiPending | nmiEdge;
    case (state)
      IDLE: begin
        if (bus.instructionBoundary) begin
          if (nmiPending) begin
            nextKind  = K_NMI;
            nextState = S1;
          end else if (bus.interruptRequest && !bus.interruptDisable) begin
            nextKind  = K_IRQ;
            nextState = S1;
          end else if (bus.brkRequest) begin
            nextKind  = K_BRK;
            nextState = S1;
          end
        end
      end
      S1: nextState = S2;
      S2: nextState = S3;
      S3: nextState = S4;
      S4: nextState = S5;
      S5: begin
        nextState = S6;
        // A late NMI steals an IRQ/BRK entry; the B bit already pushed stays as is.
        if (nmiPending && (kind == K_IRQ || kind == K_BRK))
          nextKind = K_NMI;
        if (nextKind == K_NMI)
          nextNmiPending = 1'b0;
      end
      S6: nextState = S7;
      S7: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    case (kind)
      K_NMI:   vecLo = 8'hFA;
      K_RESET: vecLo = 8'hFC;
      default: vecLo = 8'hFE;
    endcase
  end

  always_comb begin
    bus.busy                = (state != IDLE);
    bus.addressHigh         = bus.pcHigh;
    bus.addressLow          = bus.pcLow;
    bus.dataOut             = 8'h00;
    bus.writeEnable         = 1'b0;
    bus.spDecrement         = 1'b0;
    bus.loadPcLow           = 1'b0;
    bus.loadPcHigh          = 1'b0;
    bus.setInterruptDisable = 1'b0;
    case (state)
      S3, S4, S5: begin
        bus.addressHigh = 8'h01;
        bus.addressLow  = bus.stackPointer;
        bus.spDecrement = 1'b1;
        // Reset walks S down with reads only.
        bus.writeEnable = (kind != K_RESET);
        case (state)
          S3:      bus.dataOut = bus.pcHigh;
          S4:      bus.dataOut = bus.pcLow;
          default: bus.dataOut = {bus.statusReg[7:6], 1'b1, (kind == K_BRK), bus.statusReg[3:0]};
        endcase
      end
      S6: begin
        bus.addressHigh         = 8'hFF;
        bus.addressLow          = vecLo;
        bus.loadPcLow           = 1'b1;
        bus.setInterruptDisable = 1'b1;
      end
      S7: begin
        bus.addressHigh = 8'hFF;
        bus.addressLow  = vecLo + 8'd1;
        bus.loadPcHigh  = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_interrupt_sequencer.sv
// Scoreboard bench: a transaction-level model predicts each sequencer bus cycle,
// a monitor compares every cycle; the driver also plays the core (S, PC, I updates).
module tb_interrupt_sequencer;
  logic tb_clk = 1'b0;
  logic rst = 1'b0;
  always #5 tb_clk = ~tb_clk;

  interrupt_sequencer_if bus();
  interrupt_sequencer dut (.clk(tb_clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [29:0] v; } expT;
  expT exp[$];

  int cyc = 0;
  always @(posedge tb_clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  bit monOn = 1'b0;

  // core-side registers
  logic [15:0] pc = 16'h0000;
  logic [7:0]  p = 8'h00;
  logic [7:0]  sp = 8'h00;
  bit          iFlag = 1'b0;
  logic [7:0]  vecMem [6];

  // model: pos = sequence step of the current cycle (0 idle), kind 0 RESET 1 NMI 2 IRQ 3 BRK
  int pos = 0;
  int kind = 0;
  bit pend = 1'b0;
  bit nPrev = 1'b0;
  bit inRst = 1'b0;

  function automatic logic [7:0] vecByte(logic [15:0] a);
    if (a >= 16'hFFFA) return vecMem[int'(a[2:0]) - 2];
    return 8'h00;
  endfunction

  // Expected bus cycle k (1..7) of a kind-kd entry: {busy, addr, we, data, spDec, ldLo, ldHi, setI}
  function automatic logic [29:0] ent(int k, int kd);
    logic [15:0] a; logic [7:0] d, s1, s2, vl; logic we, spd, lpl, lph, sid;
    a = pc; d = 8'h00; we = 1'b0; spd = 1'b0; lpl = 1'b0; lph = 1'b0; sid = 1'b0;
    s1 = sp - 8'd1; s2 = sp - 8'd2;
    vl = (kd == 1) ? 8'hFA : (kd == 0) ? 8'hFC : 8'hFE;
    case (k)
      3: begin a = {8'h01, sp}; d = pc[15:8]; spd = 1'b1; we = (kd != 0); end
      4: begin a = {8'h01, s1}; d = pc[7:0];  spd = 1'b1; we = (kd != 0); end
      5: begin
        a = {8'h01, s2}; spd = 1'b1; we = (kd != 0);
        d = ((p | 8'h20) & 8'hEF) | ((kd == 3) ? 8'h10 : 8'h00);
      end
      6: begin a = {8'hFF, vl}; lpl = 1'b1; sid = 1'b1; end
      7: begin vl = vl + 8'd1; a = {8'hFF, vl}; lph = 1'b1; end
      default: ;
    endcase
    return {1'b1, a, we, d, spd, lpl, lph, sid};
  endfunction

  task automatic push(int c, logic [29:0] v);
    expT e;
    e.cyc = c; e.v = v;
    exp.push_back(e);
  endtask

  task automatic step(input bit r, input bit n, input bit q, input bit b, input bit bd);
    logic dec, lo, hi, si; logic [15:0] a; int c; bit e;
    @(negedge tb_clk);
    dec = bus.spDecrement; lo = bus.loadPcLow; hi = bus.loadPcHigh; si = bus.setInterruptDisable;
    a = {bus.addressHigh, bus.addressLow};
    @(posedge tb_clk); #1;
    if (dec === 1'b1) sp = sp - 8'd1;
    if (lo === 1'b1) pc[7:0] = vecByte(a);
    if (hi === 1'b1) pc[15:8] = vecByte(a);
    if (si === 1'b1) iFlag = 1'b1;
    rst = r;
    bus.nonMaskableInterrupt = n; bus.interruptRequest = q; bus.brkRequest = b;
    bus.instructionBoundary = bd; bus.interruptDisable = iFlag;
    bus.pcHigh = pc[15:8]; bus.pcLow = pc[7:0]; bus.statusReg = p; bus.stackPointer = sp;
    c = cyc;
    monOn = 1'b1;
    if (r) begin
      exp.delete();
      pos = 1; kind = 0; pend = 1'b0; nPrev = 1'b0; inRst = 1'b1;
      push(c, ent(1, 0));
      return;
    end
    if (inRst) begin
      inRst = 1'b0;
      for (int k = 1; k <= 5; k++) push(c + k - 1, ent(k, 0));
    end
    e = n && !nPrev;
    nPrev = n;
    if (pos == 0) begin
      if (bd) begin
        if (pend) kind = 1;
        else if (q && !iFlag) kind = 2;
        else if (b) kind = 3;
        else kind = -1;
        if (kind >= 0) begin
          for (int k = 1; k <= 5; k++) push(c + k, ent(k, kind));
          pos = 1;
        end
      end
      if (e) pend = 1'b1;
    end else if (pos == 5) begin
      if (pend && (kind == 2 || kind == 3)) kind = 1;
      push(c + 1, ent(6, kind));
      push(c + 2, ent(7, kind));
      if (kind == 1) pend = 1'b0;
      else if (e) pend = 1'b1;
      pos = 6;
    end else begin
      pos = (pos == 7) ? 0 : pos + 1;
      if (e) pend = 1'b1;
    end
  endtask

  // monitor: every cycle either matches its predicted bus cycle or must be idle
  initial begin
    expT e; logic [29:0] act;
    forever begin
      @(negedge tb_clk);
      if (monOn) begin
        act = {bus.busy, bus.addressHigh, bus.addressLow, bus.writeEnable, bus.dataOut,
               bus.spDecrement, bus.loadPcLow, bus.loadPcHigh, bus.setInterruptDisable};
        tests++;
        if (exp.size() > 0 && exp[0].cyc == cyc) begin
          e = exp.pop_front();
          if (act !== e.v) begin
            fails++;
            $display("FAIL seqCycle cyc=%0d got %h expected %h", cyc, act, e.v);
          end
        end else if (bus.busy !== 1'b0) begin
          fails++;
          $display("FAIL idleBusy cyc=%0d busy=%b expected 0", cyc, bus.busy);
        end
      end
    end
  end

  initial begin
    bit nmiLvl, irqLvl, r, b, bd;
    for (int i = 0; i < 6; i++) vecMem[i] = 8'($urandom);
    // reset release: PC=1234, S=FD
    pc = 16'h1234; sp = 8'hFD; p = 8'h00; iFlag = 1'b0;
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    // IRQ with I=0
    pc = 16'h8042; p = 8'h20; sp = 8'hFF; iFlag = 1'b0;
    step(0, 0, 1, 0, 1);
    repeat (9) step(0, 0, 0, 0, 0);
    // IRQ masked, BRK taken, P=00 pushed as 30
    pc = 16'h4000; p = 8'h00; sp = 8'hF0; iFlag = 1'b1;
    step(0, 0, 1, 1, 1);
    repeat (9) step(0, 0, 1, 0, 0);
    // NMI edge in IRQ S3 hijacks the vector
    pc = 16'hC123; p = 8'h81; sp = 8'hE0; iFlag = 1'b0;
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0);
    // NMI and IRQ at the same boundary, IRQ follows
    pc = 16'h2000; p = 8'h04; sp = 8'hD0; iFlag = 1'b0;
    step(0, 0, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0); step(0, 1, 1, 0, 1);
    repeat (7) step(0, 0, 1, 0, 0);
    iFlag = 1'b0;
    step(0, 0, 1, 0, 1);
    repeat (9) step(0, 0, 0, 0, 0);
    // reset during IRQ S4
    pc = 16'h5555; p = 8'h00; sp = 8'hC0; iFlag = 1'b0;
    step(0, 0, 1, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0);
    // randomized traffic
    nmiLvl = 1'b0; irqLvl = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 399) == 0);
      if (pos == 0 && !inRst) begin
        pc = 16'($urandom); p = 8'($urandom); sp = 8'($urandom);
        iFlag = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 24) == 0) nmiLvl = !nmiLvl;
      if ($urandom_range(0, 9) == 0) irqLvl = !irqLvl;
      b  = ($urandom_range(0, 3) == 0);
      bd = ($urandom_range(0, 2) == 0);
      step(r, nmiLvl, irqLvl, b, bd);
    end
    repeat (10) step(0, 0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
